// File: rtl/mult_seq_ctrl_141088.sv
// Sequencer for the 4x4 signed Baugh-Wooley multiplier: latches partial products,
// waits for the external reduction tree to settle, then captures/accumulates the product.
module mult_seq_ctrl_141088 #(
  parameter int SETTLE_CYC = 1,
  parameter int ACC_W      = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic [3:0]       pp0,
  output logic [3:0]       pp1,
  output logic [3:0]       pp2,
  output logic [3:0]       pp3,
  input  logic [7:0]       y_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             acc_ovf,
  output logic [7:0]       op_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [3:0][3:0]        pp_q, pp_d;
  logic                   acc_en_q, acc_en_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic [ACC_W-1:0]       res_q, res_d;
  logic [7:0]             opc_q, opc_d;

  logic                   capture;
  logic [ACC_W-1:0]       p, acc_base, sum;
  logic                   ovf_new;

  // Sign bits of the last row/column are inverted; the reduction tree adds the constants.
  always_comb begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        pp_d[i][j] = (a[j] & b[i]) ^ ((i == 3) ^ (j == 3));
  end

  assign capture  = (state_q == SETTLE) && (cnt_q == 4'd0);
  assign p        = ACC_W'($signed(y_in));
  assign acc_base = acc_clr ? '0 : acc_q;
  assign sum      = acc_base + p;
  assign ovf_new  = (acc_base[ACC_W-1] == p[ACC_W-1]) && (sum[ACC_W-1] != p[ACC_W-1]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_en_d = acc_en_q;
    res_d    = res_q;
    opc_d    = opc_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    // A clear in any state wins over the stale accumulator value
    if (acc_clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_en_d = acc_en;
          cnt_d    = 4'(SETTLE_CYC - 1);
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (acc_en_q) begin
            res_d = sum;
            acc_d = sum;
            ovf_d = ovf_d | ovf_new;
          end else begin
            res_d = p;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          opc_d   = opc_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pp_q     <= '0;
      acc_en_q <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      res_q    <= '0;
      opc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_en_q <= acc_en_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      res_q    <= res_d;
      opc_q    <= opc_d;
      if (state_q == IDLE && in_valid) pp_q <= pp_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign pp0       = pp_q[0];
  assign pp1       = pp_q[1];
  assign pp2       = pp_q[2];
  assign pp3       = pp_q[3];
  assign result    = res_q;
  assign acc_ovf   = ovf_q;
  assign op_cnt    = opc_q;

  // capture only ever fires from SETTLE; kept as a named term for readability
  logic unused_capture;
  assign unused_capture = capture;

endmodule

// File: tb/tb_mult_seq_ctrl_141088.sv
// Randomized + directed bench for mult_seq_ctrl_141088: two instances (12-bit/1-cycle and
// 8-bit/3-cycle) against a plain-arithmetic reference model and a reduction-tree model.
module tb_mult_seq_ctrl_141088;

  localparam int WID[2] = '{12, 8};
  localparam int STL[2] = '{1, 3};

  logic       clk, rst;
  logic       iv[2], ir[2], en_s[2], clr_s[2], ov[2], ordy[2], ovf[2];
  logic [3:0] a_s[2], b_s[2];
  logic [3:0] pp[2][4];
  logic [7:0] y[2], opc[2];
  logic [11:0] res0;
  logic [7:0]  res1;
  logic [31:0] res_w[2];

  int n_chk, n_fail;
  int acc_m[2], cnt_m[2];
  bit ovf_m[2];
  logic [15:0] pp_seen[2];

  // Reduction tree: shifted partial products plus the Baugh-Wooley constants 2^4 and 2^7.
  function automatic logic [7:0] pprr(logic [3:0] q0, q1, q2, q3);
    int s;
    s = int'(q0) + (int'(q1) << 1) + (int'(q2) << 2) + (int'(q3) << 3) + 16 + 128;
    return 8'(s);
  endfunction

  always_comb y[0] = pprr(pp[0][0], pp[0][1], pp[0][2], pp[0][3]);
  always_comb y[1] = pprr(pp[1][0], pp[1][1], pp[1][2], pp[1][3]);
  assign res_w[0] = {20'b0, res0};
  assign res_w[1] = {24'b0, res1};

  mult_seq_ctrl_141088 #(.SETTLE_CYC(1), .ACC_W(12)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_s[0]), .b(b_s[0]),
    .acc_en(en_s[0]), .acc_clr(clr_s[0]), .pp0(pp[0][0]), .pp1(pp[0][1]), .pp2(pp[0][2]),
    .pp3(pp[0][3]), .y_in(y[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .result(res0),
    .acc_ovf(ovf[0]), .op_cnt(opc[0]));

  mult_seq_ctrl_141088 #(.SETTLE_CYC(3), .ACC_W(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_s[1]), .b(b_s[1]),
    .acc_en(en_s[1]), .acc_clr(clr_s[1]), .pp0(pp[1][0]), .pp1(pp[1][1]), .pp2(pp[1][2]),
    .pp3(pp[1][3]), .y_in(y[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .result(res1),
    .acc_ovf(ovf[1]), .op_cnt(opc[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int wrapw(int x, int w);
    logic [31:0] u;
    u = 32'(x) & ((32'd1 << w) - 32'd1);
    if (u >= (32'd1 << (w - 1))) return int'(u) - (1 << w);
    return int'(u);
  endfunction

  function automatic logic [31:0] mask(int x, int w);
    return 32'(x) & ((32'd1 << w) - 32'd1);
  endfunction

  // One complete operation on instance k; entered and left on a falling edge.
  task automatic do_op(input int k, input logic [3:0] ai, bi, input bit en, clr, input int dly);
    int lat, p, s, exp_res;
    logic [31:0] held;
    chk("in_ready_idle", 32'(ir[k]), 32'd1);
    a_s[k] = ai; b_s[k] = bi; en_s[k] = en; iv[k] = 1'b1;
    @(negedge clk);
    iv[k] = 1'b0;
    a_s[k] = 4'($urandom); b_s[k] = 4'($urandom); en_s[k] = 1'($urandom);
    pp_seen[k] = {pp[k][3], pp[k][2], pp[k][1], pp[k][0]};
    if (clr) clr_s[k] = 1'b1;
    lat = 0;
    while (!ov[k] && lat < 40) begin
      chk("in_ready_settle", 32'(ir[k]), 32'd0);
      @(negedge clk);
      lat++;
    end
    clr_s[k] = 1'b0;
    p = int'($signed(ai)) * int'($signed(bi));
    if (en) begin
      if (clr) begin acc_m[k] = 0; ovf_m[k] = 0; end
      s = acc_m[k] + p;
      if (s > (1 << (WID[k] - 1)) - 1 || s < -(1 << (WID[k] - 1))) ovf_m[k] = 1;
      acc_m[k] = wrapw(s, WID[k]);
      exp_res = acc_m[k];
    end else begin
      if (clr) begin acc_m[k] = 0; ovf_m[k] = 0; end
      exp_res = p;
    end
    chk("latency", 32'(lat), 32'(STL[k]));
    chk("result", res_w[k], mask(exp_res, WID[k]));
    chk("acc_ovf", 32'(ovf[k]), 32'(ovf_m[k]));
    chk("in_ready_done", 32'(ir[k]), 32'd0);
    held = res_w[k];
    repeat (dly) begin
      @(negedge clk);
      chk("hold_valid", 32'(ov[k]), 32'd1);
      chk("hold_result", res_w[k], held);
      chk("hold_in_ready", 32'(ir[k]), 32'd0);
    end
    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
    cnt_m[k] = (cnt_m[k] + 1) % 256;
    chk("valid_drop", 32'(ov[k]), 32'd0);
    chk("op_cnt", 32'(opc[k]), 32'(cnt_m[k]));
  endtask

  task automatic pulse_clr(input int k);
    clr_s[k] = 1'b1;
    @(negedge clk);
    clr_s[k] = 1'b0;
    acc_m[k] = 0;
    ovf_m[k] = 0;
    chk("clr_ovf", 32'(ovf[k]), 32'd0);
  endtask

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      acc_m[k] = 0; cnt_m[k] = 0; ovf_m[k] = 0;
    end
  endtask

  task automatic chk_reset(input int k);
    chk("rst_result", res_w[k], 32'd0);
    chk("rst_valid", 32'(ov[k]), 32'd0);
    chk("rst_ovf", 32'(ovf[k]), 32'd0);
    chk("rst_opcnt", 32'(opc[k]), 32'd0);
    chk("rst_pp", {16'b0, pp[k][3], pp[k][2], pp[k][1], pp[k][0]}, 32'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 0; en_s[k] = 0; clr_s[k] = 0; ordy[k] = 0; a_s[k] = 0; b_s[k] = 0;
    end
    reset_model();
    repeat (2) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst = 1'b0;
    @(negedge clk);

    // Directed: 5*3, pattern of partial products
    do_op(0, 4'b0101, 4'b0011, 1'b0, 1'b0, 0);
    chk("pp_5x3", {16'b0, pp_seen[0]}, 32'h0000_78DD);
    do_op(0, 4'b1000, 4'b1000, 1'b0, 1'b0, 1);
    chk("pp_m8xm8", {16'b0, pp_seen[0]}, 32'h0000_F888);
    do_op(0, 4'b0111, 4'b1000, 1'b0, 1'b0, 0);
    chk("res_7xm8", res_w[0], 32'h0000_0FC8);

    // Accumulate 15, 7, 56
    pulse_clr(0);
    do_op(0, 4'd3, 4'd5, 1'b1, 1'b0, 0);
    do_op(0, 4'b1110, 4'd4, 1'b1, 1'b0, 0);
    do_op(0, 4'd7, 4'd7, 1'b1, 1'b0, 0);
    chk("acc_56", res_w[0], 32'd56);

    // 8-bit accumulator overflow: 49, 98, 147 -> wraps negative, sticky
    pulse_clr(1);
    do_op(1, 4'd7, 4'd7, 1'b1, 1'b0, 0);
    do_op(1, 4'd7, 4'd7, 1'b1, 1'b0, 0);
    do_op(1, 4'd7, 4'd7, 1'b1, 1'b0, 0);
    chk("ovf_set", 32'(ovf[1]), 32'd1);
    do_op(1, 4'd1, 4'd1, 1'b1, 1'b0, 5);
    chk("ovf_sticky", 32'(ovf[1]), 32'd1);
    pulse_clr(1);

    // Clear on the capture edge: result is the bare product
    do_op(0, 4'd2, 4'd3, 1'b1, 1'b1, 0);
    do_op(1, 4'b1001, 4'd7, 1'b1, 1'b1, 2);

    // Reset mid-SETTLE
    a_s[1] = 4'd5; b_s[1] = 4'd5; en_s[1] = 1'b1; iv[1] = 1'b1;
    @(negedge clk);
    iv[1] = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset(1);
    chk_reset(0);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    @(negedge clk);
    chk("post_rst_ready", 32'(ir[1]), 32'd1);
    do_op(1, 4'd5, 4'd5, 1'b1, 1'b0, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      int k;
      k = int'($urandom_range(0, 1));
      do_op(k, 4'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 3)));
      if ($urandom_range(0, 9) == 0) pulse_clr(k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
